// File: rtl/ring_buffer_if.sv
// -----------------------------------------------------------------------------
// ring_buffer_if
//   Groups the producer/consumer signals of ring_buffer into one bundle.
//
//   Parameters
//     DATA_W   width of data_in / data_out
//     DEPTH    number of FIFO entries (power of 2, >= 2)
//
//   Signals
//     wr_en     write request (producer -> FIFO)
//     rd_en     read request (consumer -> FIFO)
//     data_in   write data (producer -> FIFO)
//     data_out  registered read data (FIFO -> consumer)
//     full      FIFO holds DEPTH entries
//     empty     FIFO holds no entries
//     overflow, underflow, level
//               only present when RING_BUFFER_ERR_FLAGS_EN is defined
//
//   Modports
//     master    producer/consumer side
//     slave     the FIFO itself
// -----------------------------------------------------------------------------
interface ring_buffer_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
);
   localparam int ADDR_W = $clog2(DEPTH);

   logic              wr_en;
   logic              rd_en;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;
   logic              full;
   logic              empty;
`ifdef RING_BUFFER_ERR_FLAGS_EN
   logic              overflow;
   logic              underflow;
   logic [ADDR_W:0]   level;
`endif

   modport master (
      output wr_en, rd_en, data_in,
      input  data_out, full, empty
`ifdef RING_BUFFER_ERR_FLAGS_EN
      , input overflow, underflow, level
`endif
   );

   modport slave (
      input  wr_en, rd_en, data_in,
      output data_out, full, empty
`ifdef RING_BUFFER_ERR_FLAGS_EN
      , output overflow, underflow, level
`endif
   );
endinterface

// File: rtl/ring_buffer.sv
// -----------------------------------------------------------------------------
// ring_buffer
//   Single-clock ring-buffer FIFO with registered read data and registered
//   full/empty flags. Storage is a plain array so it can map to block RAM;
//   the read port is the data_out register itself.
//
//   Parameters
//     DATA_W   data width (default 8)
//     DEPTH    entries, power of 2 and >= 2 (default 4)
//
//   Ports
//     clk      clock, rising edge
//     rst      asynchronous reset, active low
//     bus      ring_buffer_if.slave: wr_en, rd_en, data_in, data_out,
//              full, empty (+ overflow, underflow, level when enabled)
//
//   Build option
//     RING_BUFFER_ERR_FLAGS_EN  adds sticky overflow/underflow flags and a
//                               level output; core behaviour is unchanged.
// -----------------------------------------------------------------------------
module ring_buffer #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic           clk,
   input  logic           rst,
   ring_buffer_if.slave   bus
);
   localparam int ADDR_W = $clog2(DEPTH);
   localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];

   logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic [ADDR_W:0]   count_reg, count_next;
   logic              full_reg, full_next;
   logic              empty_reg, empty_next;
   logic [DATA_W-1:0] data_out_reg;
   logic              do_wr;
   logic              do_rd;

   // Accept decisions use the registered flags, i.e. the state before the edge.
   always_comb begin
      do_wr       = bus.wr_en & ~full_reg;
      do_rd       = bus.rd_en & ~empty_reg;
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (do_wr) begin
         wr_ptr_next = wr_ptr_reg + 1'b1;   // natural wrap, DEPTH is a power of 2
      end
      if (do_rd) begin
         rd_ptr_next = rd_ptr_reg + 1'b1;
      end
      if (do_wr && !do_rd) begin
         count_next = count_reg + 1'b1;
      end else if (do_rd && !do_wr) begin
         count_next = count_reg - 1'b1;
      end
      // Flags are registered from the next count so they move with it.
      full_next  = (count_next == FULL_COUNT);
      empty_next = (count_next == '0);
   end

   // Storage has no reset so it stays inferable as RAM.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr_reg] <= bus.data_in;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         full_reg     <= 1'b0;
         empty_reg    <= 1'b1;
         data_out_reg <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
         full_reg   <= full_next;
         empty_reg  <= empty_next;
         // Read of the old slot only; a same-cycle write into an empty
         // buffer is never forwarded to data_out.
         if (do_rd) begin
            data_out_reg <= mem[rd_ptr_reg];
         end
      end
   end

   assign bus.data_out = data_out_reg;
   assign bus.full     = full_reg;
   assign bus.empty    = empty_reg;

`ifdef RING_BUFFER_ERR_FLAGS_EN
   logic overflow_reg;
   logic underflow_reg;

   // Sticky: any rejected request since reset leaves its flag set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         if (bus.wr_en && full_reg) begin
            overflow_reg <= 1'b1;
         end
         if (bus.rd_en && empty_reg) begin
            underflow_reg <= 1'b1;
         end
      end
   end

   assign bus.overflow  = overflow_reg;
   assign bus.underflow = underflow_reg;
   assign bus.level     = count_reg;
`endif

endmodule

// File: tb/tb_ring_buffer.sv
// -----------------------------------------------------------------------------
// tb_ring_buffer
//   Self-checking bench for ring_buffer. A queue holds the data expected to
//   come out; it is pushed on every accepted write and popped on every
//   accepted read, and each scenario task compares the DUT against it.
// -----------------------------------------------------------------------------
module tb_ring_buffer;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 4;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   ring_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   ring_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   logic [DATA_W-1:0] sb_q[$];
   logic [DATA_W-1:0] exp_dout = '0;
   logic              exp_ovf  = 1'b0;
   logic              exp_unf  = 1'b0;

   // Drive one cycle of stimulus, advance past the edge, update the model.
   task automatic cycle(input logic wr, input logic rd, input logic [DATA_W-1:0] din);
      bit acc_wr;
      bit acc_rd;
      acc_wr = wr && (sb_q.size() != DEPTH);
      acc_rd = rd && (sb_q.size() != 0);
      if (wr && sb_q.size() == DEPTH) exp_ovf = 1'b1;
      if (rd && sb_q.size() == 0)     exp_unf = 1'b1;
      bus.wr_en   = wr;
      bus.rd_en   = rd;
      bus.data_in = din;
      @(posedge clk);
      #1;
      if (acc_rd) exp_dout = sb_q.pop_front();
      if (acc_wr) sb_q.push_back(din);
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      $display("txn t=%0t wr=%0b rd=%0b din=%h -> dout=%h full=%0b empty=%0b model_cnt=%0d",
               $time, wr, rd, din, bus.data_out, bus.full, bus.empty, sb_q.size());
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.data_in = '0;
      repeat (2) @(posedge clk);
      #1;
      sb_q.delete(); exp_dout = '0; exp_ovf = 1'b0; exp_unf = 1'b0;
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", bus.empty); end
      checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", bus.full); end
      checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", bus.data_out); end
`ifdef RING_BUFFER_ERR_FLAGS_EN
      checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", bus.level); end
`endif
      #3 rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_fill();
      logic [DATA_W-1:0] vals [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 1'b0, vals[i]);
         checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL fill_empty[%0d] got %b exp 0", i, bus.empty); end
         checks++; if (bus.full !== (i == 3)) begin errors++; $display("FAIL fill_full[%0d] got %b exp %b", i, bus.full, (i == 3)); end
      end
      cycle(1'b1, 1'b0, 8'hEE);
      checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL overfill_full got %b exp 1", bus.full); end
      checks++; if (bus.data_out !== exp_dout) begin errors++; $display("FAIL overfill_dout got %h exp %h", bus.data_out, exp_dout); end
`ifdef RING_BUFFER_ERR_FLAGS_EN
      checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL overflow got %b exp 1", bus.overflow); end
      checks++; if (bus.level !== 3'd4) begin errors++; $display("FAIL overfill_level got %0d exp 4", bus.level); end
`endif
   endtask

   task automatic test_drain();
      logic [DATA_W-1:0] vals [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b1, 8'h00);
         checks++; if (bus.data_out !== vals[i] || bus.data_out !== exp_dout) begin errors++; $display("FAIL drain_dout[%0d] got %h exp %h", i, bus.data_out, vals[i]); end
         checks++; if (bus.empty !== (i == 3)) begin errors++; $display("FAIL drain_empty[%0d] got %b exp %b", i, bus.empty, (i == 3)); end
         checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL drain_full[%0d] got %b exp 0", i, bus.full); end
      end
      cycle(1'b0, 1'b1, 8'h00);
      checks++; if (bus.data_out !== 8'hDD) begin errors++; $display("FAIL underread_dout got %h exp DD", bus.data_out); end
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL underread_empty got %b exp 1", bus.empty); end
`ifdef RING_BUFFER_ERR_FLAGS_EN
      checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL underflow got %b exp 1", bus.underflow); end
      checks++; if (bus.overflow !== exp_ovf) begin errors++; $display("FAIL overflow_sticky got %b exp %b", bus.overflow, exp_ovf); end
`endif
   endtask

   task automatic test_wrap();
      logic [DATA_W-1:0] outs [4] = '{8'h22, 8'h33, 8'h44, 8'h55};
      cycle(1'b1, 1'b0, 8'h11);
      cycle(1'b1, 1'b0, 8'h22);
      cycle(1'b0, 1'b1, 8'h00);
      checks++; if (bus.data_out !== 8'h11) begin errors++; $display("FAIL wrap_first got %h exp 11", bus.data_out); end
      cycle(1'b1, 1'b0, 8'h33);
      cycle(1'b1, 1'b0, 8'h44);
      checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL wrap_prefull got %b exp 0", bus.full); end
      cycle(1'b1, 1'b0, 8'h55);
      checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL wrap_full got %b exp 1", bus.full); end
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b1, 8'h00);
         checks++; if (bus.data_out !== outs[i] || bus.data_out !== exp_dout) begin errors++; $display("FAIL wrap_dout[%0d] got %h exp %h", i, bus.data_out, outs[i]); end
      end
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b exp 1", bus.empty); end
   endtask

   task automatic test_simultaneous();
      cycle(1'b1, 1'b0, 8'h77);
      cycle(1'b1, 1'b0, 8'h88);
      // Middle occupancy: both accepted, count unchanged.
      cycle(1'b1, 1'b1, 8'h66);
      checks++; if (bus.data_out !== 8'h77) begin errors++; $display("FAIL sim_mid_dout got %h exp 77", bus.data_out); end
      checks++; if (bus.empty !== 1'b0 || bus.full !== 1'b0) begin errors++; $display("FAIL sim_mid_flags got e=%b f=%b exp e=0 f=0", bus.empty, bus.full); end
`ifdef RING_BUFFER_ERR_FLAGS_EN
      checks++; if (bus.level !== 3'd2) begin errors++; $display("FAIL sim_mid_level got %0d exp 2", bus.level); end
`endif
      cycle(1'b1, 1'b0, 8'h99);
      cycle(1'b1, 1'b0, 8'hAB);
      checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL sim_prefull got %b exp 1", bus.full); end
      // Full: only the read goes through.
      cycle(1'b1, 1'b1, 8'hCD);
      checks++; if (bus.data_out !== 8'h88) begin errors++; $display("FAIL sim_full_dout got %h exp 88", bus.data_out); end
      checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL sim_full_flag got %b exp 0", bus.full); end
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b1, 8'h00);
         checks++; if (bus.data_out !== exp_dout) begin errors++; $display("FAIL sim_drain_dout[%0d] got %h exp %h", i, bus.data_out, exp_dout); end
      end
      checks++; if (bus.empty !== 1'b1 || bus.data_out !== 8'hAB) begin errors++; $display("FAIL sim_drained got e=%b dout=%h exp e=1 dout=AB", bus.empty, bus.data_out); end
      // Empty: only the write goes through, no fall-through to data_out.
      cycle(1'b1, 1'b1, 8'hEF);
      checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL sim_empty_flag got %b exp 0", bus.empty); end
      checks++; if (bus.data_out !== 8'hAB) begin errors++; $display("FAIL sim_empty_dout got %h exp AB", bus.data_out); end
      cycle(1'b0, 1'b1, 8'h00);
      checks++; if (bus.data_out !== 8'hEF || bus.data_out !== exp_dout) begin errors++; $display("FAIL sim_empty_follow got %h exp EF", bus.data_out); end
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL sim_final_empty got %b exp 1", bus.empty); end
   endtask

   task automatic test_reset_mid();
      cycle(1'b1, 1'b0, 8'h01);
      cycle(1'b1, 1'b0, 8'h02);
      cycle(1'b0, 1'b1, 8'h00);
      checks++; if (bus.data_out !== 8'h01) begin errors++; $display("FAIL mid_pre_dout got %h exp 01", bus.data_out); end
      // Assert reset between edges; it must take effect without a clock.
      #2 rst = 1'b0;
      #1;
      sb_q.delete(); exp_dout = '0; exp_ovf = 1'b0; exp_unf = 1'b0;
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL mid_rst_empty got %b exp 1", bus.empty); end
      checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL mid_rst_dout got %h exp 00", bus.data_out); end
`ifdef RING_BUFFER_ERR_FLAGS_EN
      checks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin errors++; $display("FAIL mid_rst_sticky got o=%b u=%b exp 0 0", bus.overflow, bus.underflow); end
`endif
      @(posedge clk);
      #3 rst = 1'b1;
      @(posedge clk); #1;
      cycle(1'b1, 1'b0, 8'h03);
      cycle(1'b0, 1'b1, 8'h00);
      checks++; if (bus.data_out !== 8'h03 || bus.data_out !== exp_dout) begin errors++; $display("FAIL mid_resume_dout got %h exp 03", bus.data_out); end
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL mid_resume_empty got %b exp 1", bus.empty); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_wrap();
      test_simultaneous();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
